// File: rtl/sccb_cfg_pkg.sv
// Shared types and marker words for the SCCB register-configuration sequencer.
// The ROM format is {reg_addr, reg_val}; two reserved words act as markers.
package sccb_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP,
        S_DELAY,
        S_DONE,
        S_ERROR
    } cfg_state_t;

    localparam logic [15:0] CFG_END_MARK   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY_MARK = 16'hFFF0;

endpackage

// File: rtl/cfg_wait_timer.sv
// Loadable down-counter used for both the post-write gap and the settle delay.
// zero is asserted while the count reads 0, so a load of N stays non-zero for N cycles.
module cfg_wait_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the camera config ROM from address 0 and issues one SCCB write per entry,
// honouring settle-delay and end-of-sequence markers, with bounded NACK retries.
module sccb_config_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int GAP_CYCLES   = 200,
    parameter int MAX_RETRY    = 3,
    parameter int AUTO_START   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        wr_req,
    output logic [7:0]  wr_reg,
    output logic [7:0]  wr_val,
    input  logic        wr_ack,
    input  logic        wr_done,
    input  logic        wr_err,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // The timer is shared, so it must hold the larger of the two reload values.
    localparam int TMAX = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] DELAY_LD  = TW'(DELAY_CYCLES);
    localparam logic [TW-1:0] GAP_LD    = TW'(GAP_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    cfg_state_t    state;
    cfg_state_t    state_nx;
    logic          auto_pend;
    logic [RW-1:0] retry_cnt;

    logic          seq_clr;
    logic          addr_inc;
    logic          latch_wr;
    logic          retry_clr;
    logic          retry_inc;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          done_seen;

    cfg_wait_timer #(
        .W (TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    // A completion can land in the same cycle as the acceptance.
    assign done_seen = wr_done &&
                       ((state == S_WAIT_DONE) || ((state == S_ISSUE) && wr_ack));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        seq_clr   = 1'b0;
        addr_inc  = 1'b0;
        latch_wr  = 1'b0;
        retry_clr = 1'b0;
        retry_inc = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = GAP_LD;

        case (state)
            S_IDLE: begin
                if (start || auto_pend) begin
                    seq_clr  = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rom_data == CFG_END_MARK) begin
                    state_nx = S_DONE;
                end else if (rom_data == CFG_DELAY_MARK) begin
                    tmr_load = 1'b1;
                    tmr_val  = DELAY_LD;
                    state_nx = S_DELAY;
                end else begin
                    latch_wr = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_ack) begin
                    state_nx = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                state_nx = S_WAIT_DONE;
            end
            S_GAP, S_DELAY: begin
                if (tmr_zero) begin
                    // The last ROM slot finishes the sequence instead of wrapping.
                    if (rom_addr == 8'hFF) begin
                        state_nx = S_DONE;
                    end else begin
                        addr_inc = 1'b1;
                        state_nx = S_FETCH;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    seq_clr  = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (done_seen) begin
            if (!wr_err) begin
                retry_clr = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LD;
                state_nx  = S_GAP;
            end else if (retry_cnt < RETRY_MAX) begin
                retry_inc = 1'b1;
                state_nx  = S_ISSUE;
            end else begin
                state_nx  = S_ERROR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_pend <= (AUTO_START != 0);
            rom_addr  <= '0;
            retry_cnt <= '0;
            wr_reg    <= '0;
            wr_val    <= '0;
        end else begin
            if (state == S_IDLE) begin
                auto_pend <= 1'b0;
            end
            if (seq_clr) begin
                rom_addr <= '0;
            end else if (addr_inc) begin
                rom_addr <= rom_addr + 8'd1;
            end
            if (seq_clr || retry_clr) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            if (latch_wr) begin
                wr_reg <= rom_data[15:8];
                wr_val <= rom_data[7:0];
            end
        end
    end

    assign wr_req = (state == S_ISSUE);
    assign busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT_DONE) ||
                    (state == S_GAP)   || (state == S_DELAY);
    assign done   = (state == S_DONE);
    assign error  = (state == S_ERROR);

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer with a behavioural ROM and SCCB master.
module tb_sccb_config_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        wr_req;
    logic [7:0]  wr_reg;
    logic [7:0]  wr_val;
    logic        wr_ack = 1'b0;
    logic        wr_done = 1'b0;
    logic        wr_err = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    logic [15:0] rom [256];
    logic [15:0] wlog [$];
    int          req_cyc [$];
    int          done_cyc [$];
    int          cyc = 0;
    int          attempt = 0;
    int          nack_from = 1 << 30;
    int          nack_only = -1;
    int          checks = 0;
    int          errors = 0;

    sccb_config_sequencer #(
        .DELAY_CYCLES (50),
        .GAP_CYCLES   (4),
        .MAX_RETRY    (3),
        .AUTO_START   (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .wr_req   (wr_req),
        .wr_reg   (wr_reg),
        .wr_val   (wr_val),
        .wr_ack   (wr_ack),
        .wr_done  (wr_done),
        .wr_err   (wr_err),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rom_data = rom[rom_addr];

    // SCCB master model: ack 2 cycles after the request is seen, wr_done 20 cycles after it.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_req === 1'b1) begin
                wlog.push_back({wr_reg, wr_val});
                req_cyc.push_back(cyc);
                @(negedge clk);
                @(negedge clk);
                wr_ack = 1'b1;
                @(negedge clk);
                wr_ack = 1'b0;
                repeat (17) @(negedge clk);
                wr_err = (attempt >= nack_from) || (attempt == nack_only);
                attempt++;
                wr_done = 1'b1;
                done_cyc.push_back(cyc);
                @(negedge clk);
                wr_done = 1'b0;
                wr_err  = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int n, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [15:0] e2,
                           input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        chk({tag, "_count"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wlog.size()) chk($sformatf("%s_w%0d", tag, i), 32'(wlog[i]), 32'(e[i]));
        end
    endtask

    task automatic wait_end(input int budget, input string tag);
        int n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finish_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_logs(input int cnt, input int budget, input string tag);
        int n = 0;
        while (wlog.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_writes_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_rom(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    task automatic clear_logs();
        wlog.delete();
        req_cyc.delete();
        done_cyc.delete();
        attempt = 0;
    endtask

    initial begin
        int ack_wait;
        int bad;

        // Basic three-write sequence, started by AUTO_START after reset
        load_rom(16'h1280, 16'h1214, 16'h40D0, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_wr_regval", 32'({wr_reg, wr_val}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("autostart_busy", 32'(busy), 32'd1);
        chk("autostart_addr", 32'(rom_addr), 32'd0);
        wait_end(2000, "seq3");
        chk_log("seq3", 3, 16'h1280, 16'h1214, 16'h40D0, 16'h0, 16'h0);
        chk("seq3_done", 32'(done), 32'd1);
        chk("seq3_busy", 32'(busy), 32'd0);
        chk("seq3_error", 32'(error), 32'd0);
        chk("seq3_addr", 32'(rom_addr), 32'd3);

        // Rerun from DONE, with a start pulse while busy that must be ignored
        clear_logs();
        pulse_start();
        chk("rerun_done_drop", 32'(done), 32'd0);
        chk("rerun_busy", 32'(busy), 32'd1);
        chk("rerun_addr0", 32'(rom_addr), 32'd0);
        wait_logs(2, 500, "rerun");
        pulse_start();
        chk("busy_start_addr", 32'(rom_addr), 32'd1);
        chk("busy_start_busy", 32'(busy), 32'd1);
        wait_end(2000, "rerun");
        chk_log("rerun", 3, 16'h1280, 16'h1214, 16'h40D0, 16'h0, 16'h0);
        chk("rerun_done", 32'(done), 32'd1);

        // Settle-delay marker
        load_rom(16'h1280, 16'hFFF0, 16'h1180, 16'hFFFF);
        clear_logs();
        pulse_start();
        wait_end(3000, "delay");
        chk_log("delay", 2, 16'h1280, 16'h1180, 16'h0, 16'h0, 16'h0);
        chk("delay_done", 32'(done), 32'd1);
        if (req_cyc.size() >= 2 && done_cyc.size() >= 1)
            chk("delay_gap_ge51", 32'((req_cyc[1] - done_cyc[0]) >= 51), 32'd1);
        else
            chk("delay_timestamps", 32'(req_cyc.size()), 32'd2);

        // One NACK on entry 1, then success
        load_rom(16'h1280, 16'h1180, 16'hFFFF, 16'hFFFF);
        clear_logs();
        nack_only = 1;
        pulse_start();
        wait_end(3000, "retry1");
        chk_log("retry1", 3, 16'h1280, 16'h1180, 16'h1180, 16'h0, 16'h0);
        chk("retry1_done", 32'(done), 32'd1);
        chk("retry1_error", 32'(error), 32'd0);

        // Every attempt on entry 1 NACKed: 4 attempts then error
        clear_logs();
        nack_only = -1;
        nack_from = 1;
        pulse_start();
        wait_end(5000, "retry_x");
        chk_log("retry_x", 5, 16'h1280, 16'h1180, 16'h1180, 16'h1180, 16'h1180);
        chk("retry_x_error", 32'(error), 32'd1);
        chk("retry_x_done", 32'(done), 32'd0);
        chk("retry_x_busy", 32'(busy), 32'd0);
        chk("retry_x_addr", 32'(rom_addr), 32'd1);
        repeat (20) @(negedge clk);
        chk("retry_x_hold_err", 32'(error), 32'd1);
        chk("retry_x_hold_addr", 32'(rom_addr), 32'd1);
        nack_from = 1 << 30;

        // Reset while waiting for wr_done, then automatic restart from address 0
        load_rom(16'h1280, 16'h1214, 16'h40D0, 16'hFFFF);
        clear_logs();
        pulse_start();
        ack_wait = 0;
        while (wr_ack !== 1'b1 && ack_wait < 200) begin
            @(negedge clk);
            ack_wait++;
        end
        chk("rstmid_ack_seen", 32'(ack_wait < 200), 32'd1);
        @(negedge clk);
        chk("rstmid_in_wait_req", 32'(wr_req), 32'd0);
        chk("rstmid_in_wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_wr_req", 32'(wr_req), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        wlog.delete();
        @(negedge clk);
        chk("rstmid_restart_busy", 32'(busy), 32'd1);
        wait_end(3000, "rstmid");
        chk_log("rstmid", 3, 16'h1280, 16'h1214, 16'h40D0, 16'h0, 16'h0);
        chk("rstmid_done", 32'(done), 32'd1);

        // Full ROM with no terminator
        for (int i = 0; i < 256; i++) rom[i] = {8'(i), 8'(i) ^ 8'h5A};
        clear_logs();
        pulse_start();
        wait_end(20000, "rom256");
        chk("rom256_count", 32'(wlog.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wlog.size() && i < 256; i++) begin
            if (wlog[i] !== {8'(i), 8'(i) ^ 8'h5A}) bad++;
        end
        chk("rom256_data", 32'(bad), 32'd0);
        chk("rom256_done", 32'(done), 32'd1);
        chk("rom256_addr", 32'(rom_addr), 32'd255);
        repeat (10) @(negedge clk);
        chk("rom256_addr_hold", 32'(rom_addr), 32'd255);
        chk("rom256_done_hold", 32'(done), 32'd1);
        chk("rom256_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
